// File: rtl/axil_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_led_pkg
// Description : Shared types and constants for the AXI4-Lite LED PWM
//               controller: channel mode encoding, register byte offsets,
//               ID word and AXI response codes.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    // Register byte offsets
    localparam int c_OFS_CTRL      = 'h00;
    localparam int c_OFS_STATUS    = 'h04;
    localparam int c_OFS_ID        = 'h08;
    localparam int c_OFS_CH_BASE   = 'h10;
    localparam int c_OFS_CH_STRIDE = 8;

    localparam logic [31:0] c_ID_VALUE = 32'h4C45_4432;  // "LED2"

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // Byte offset of CHn_CFG; CHn_PERIOD follows 4 bytes later.
    function automatic int f_ch_cfg_ofs(input int ch);
        return c_OFS_CH_BASE + ch * c_OFS_CH_STRIDE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_led_pwm_controller_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_channel
// Description : One LED channel: period counter advanced on the shared tick,
//               blink toggle flop and registered LED output.
// Ports       : clk, rstn (async, active-low), i_tick (timebase strobe),
//               i_en (global enable), i_clr (counter/blink clear),
//               i_mode, i_period, i_duty (channel config),
//               i_cfg_wr (config write that restarts the channel),
//               o_led (registered LED drive)
// Revision    : 1.0 - initial release
// ============================================================================
module led_channel
    import axil_led_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_tick,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  led_mode_e            i_mode,
    input  logic [CNT_WIDTH-1:0] i_period,
    input  logic [CNT_WIDTH-1:0] i_duty,
    input  logic                 i_cfg_wr,
    output logic                 o_led
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_blink;
    logic                 r_led;
    logic                 w_at_end;

    // cnt >= PERIOD also covers a period shortened below the current count.
    assign w_at_end = (r_cnt >= i_period);
    assign o_led    = r_led;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            if (!i_en || i_clr || i_cfg_wr) begin
                r_cnt   <= '0;
                r_blink <= 1'b0;
            end else if (i_tick) begin
                r_cnt <= w_at_end ? '0 : r_cnt + 1'b1;
                // PERIOD=0 pins the count at 0; blink then holds its level.
                if (w_at_end && (i_period != '0)) begin
                    r_blink <= ~r_blink;
                end
            end

            if (!i_en) begin
                r_led <= 1'b0;
            end else begin
                case (i_mode)
                    LED_OFF:   r_led <= 1'b0;
                    LED_ON:    r_led <= 1'b1;
                    LED_BLINK: r_led <= r_blink;
                    LED_PWM:   r_led <= (r_cnt < i_duty);
                    default:   r_led <= 1'b0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_led_pwm_controller.sv
`default_nettype none
// ============================================================================
// Module      : axil_led_pwm_controller
// Description : AXI4-Lite slave driving NUM_CH LEDs (off/on/blink/pwm) from a
//               shared prescaled timebase.
// Ports       : s00_axi_* - AXI4-Lite slave (aclk, async active-low aresetn)
//               led_o     - registered LED drive, one bit per channel
// Revision    : 1.0 - initial release
// ============================================================================
module axil_led_pwm_controller
    import axil_led_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH             = 4,
    parameter int CNT_WIDTH          = 16,
    parameter int PRESCALE           = 100
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_CH-1:0]               led_o
);

    localparam int c_DW     = C_S_AXI_DATA_WIDTH;
    localparam int c_STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int c_IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int c_NWORDS = 2 ** c_IDX_W;
    localparam int c_PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    function automatic logic [c_IDX_W-1:0] f_idx(input int ofs);
        return c_IDX_W'(ofs / 4);
    endfunction

    // Write channel holding registers
    logic                r_aw_held, r_w_held, r_bvalid;
    logic [1:0]          r_bresp;
    logic [c_IDX_W-1:0]  r_aw_idx;
    logic [c_DW-1:0]     r_wdata;
    logic [c_STRB_W-1:0] r_wstrb;
    // Read channel
    logic                r_rvalid;
    logic [c_DW-1:0]     r_rdata;
    logic [1:0]          r_rresp;
    // Register file
    logic                 r_en, r_clr;
    led_mode_e            r_mode   [NUM_CH];
    logic [CNT_WIDTH-1:0] r_duty   [NUM_CH];
    logic [CNT_WIDTH-1:0] r_period [NUM_CH];
    // Timebase
    logic [c_PRE_W-1:0]   r_pre;
    logic                 w_tick;

    logic [c_DW-1:0]     w_rd_word [c_NWORDS];
    logic [c_NWORDS-1:0] w_rd_map, w_rd_rw;
    logic [c_DW-1:0]     w_wmask, w_wmerged;
    logic                w_do_wr, w_wr_ok;
    logic [NUM_CH-1:0]   w_cfg_wr, w_led;
    logic                w_unused;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Readies are forced low while reset is held so every output reads 0.
    assign s00_axi_awready = s00_axi_aresetn & ~r_aw_held & ~r_bvalid;
    assign s00_axi_wready  = s00_axi_aresetn & ~r_w_held & ~r_bvalid;
    assign s00_axi_arready = s00_axi_aresetn & ~r_rvalid;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = r_rresp;
    assign led_o           = w_led;

    // Readback image of every word in the address space, plus decode flags.
    always_comb begin
        for (int k = 0; k < c_NWORDS; k++) begin
            w_rd_word[k] = '0;
        end
        w_rd_map = '0;
        w_rd_rw  = '0;
        w_rd_word[f_idx(c_OFS_CTRL)][0]             = r_en;
        w_rd_map[f_idx(c_OFS_CTRL)]                 = 1'b1;
        w_rd_rw[f_idx(c_OFS_CTRL)]                  = 1'b1;
        w_rd_word[f_idx(c_OFS_STATUS)][NUM_CH-1:0]  = w_led;
        w_rd_map[f_idx(c_OFS_STATUS)]               = 1'b1;
        w_rd_word[f_idx(c_OFS_ID)]                  = c_ID_VALUE;
        w_rd_map[f_idx(c_OFS_ID)]                   = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            w_rd_word[f_idx(f_ch_cfg_ofs(i))][1:0]            = r_mode[i];
            w_rd_word[f_idx(f_ch_cfg_ofs(i))][16 +: CNT_WIDTH] = r_duty[i];
            w_rd_map[f_idx(f_ch_cfg_ofs(i))]                   = 1'b1;
            w_rd_rw[f_idx(f_ch_cfg_ofs(i))]                    = 1'b1;
            w_rd_word[f_idx(f_ch_cfg_ofs(i) + 4)][CNT_WIDTH-1:0] = r_period[i];
            w_rd_map[f_idx(f_ch_cfg_ofs(i) + 4)]                 = 1'b1;
            w_rd_rw[f_idx(f_ch_cfg_ofs(i) + 4)]                  = 1'b1;
        end
    end

    // Byte-strobe merge of the held write data over the current contents.
    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < c_STRB_W; b++) begin
            w_wmask[8*b +: 8] = {8{r_wstrb[b]}};
        end
        w_wmerged = (w_rd_word[r_aw_idx] & ~w_wmask) | (r_wdata & w_wmask);
    end

    assign w_do_wr = r_aw_held & r_w_held & ~r_bvalid;
    assign w_wr_ok = w_rd_rw[r_aw_idx];

    // A period write, or a cfg write that changes mode, restarts the channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_cfg_wr[i] = w_do_wr &&
                ((r_aw_idx == f_idx(f_ch_cfg_ofs(i) + 4)) ||
                 ((r_aw_idx == f_idx(f_ch_cfg_ofs(i))) &&
                  (w_wmerged[1:0] != r_mode[i])));
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_en      <= 1'b0;
            r_clr     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_mode[i]   <= LED_OFF;
                r_duty[i]   <= '0;
                r_period[i] <= '0;
            end
        end else begin
            r_clr <= 1'b0;
            if (s00_axi_awvalid && s00_axi_awready) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (s00_axi_wvalid && s00_axi_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= s00_axi_wdata;
                r_wstrb  <= s00_axi_wstrb;
            end
            if (w_do_wr) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
                if (w_wr_ok) begin
                    if (r_aw_idx == f_idx(c_OFS_CTRL)) begin
                        r_en  <= w_wmerged[0];
                        r_clr <= r_wstrb[0] & r_wdata[1];
                    end
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (r_aw_idx == f_idx(f_ch_cfg_ofs(i))) begin
                            r_mode[i] <= led_mode_e'(w_wmerged[1:0]);
                            r_duty[i] <= w_wmerged[16 +: CNT_WIDTH];
                        end
                        if (r_aw_idx == f_idx(f_ch_cfg_ofs(i) + 4)) begin
                            r_period[i] <= w_wmerged[CNT_WIDTH-1:0];
                        end
                    end
                end
            end else if (r_bvalid && s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end else if (s00_axi_arvalid && s00_axi_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_word[s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]];
            r_rresp  <= w_rd_map[s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]] ?
                        c_RESP_OKAY : c_RESP_SLVERR;
        end else if (r_rvalid && s00_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Prescaler: tick is high during the last count, so PRESCALE=1 ticks
    // every cycle.
    assign w_tick = r_en && (r_pre == c_PRE_W'(PRESCALE - 1));

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_pre <= '0;
        end else if (!r_en || r_clr || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            led_channel #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_led_channel (
                .clk      (s00_axi_aclk),
                .rstn     (s00_axi_aresetn),
                .i_tick   (w_tick),
                .i_en     (r_en),
                .i_clr    (r_clr),
                .i_mode   (r_mode[g]),
                .i_period (r_period[g]),
                .i_duty   (r_duty[g]),
                .i_cfg_wr (w_cfg_wr[g]),
                .o_led    (w_led[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axil_led_pwm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_led_pwm_controller
// Description : Directed self-checking bench for axil_led_pwm_controller.
//               Expected responses are queued when stimulus is issued and
//               popped when the DUT answers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_led_pwm_controller;

    localparam int AW  = 6;
    localparam int NCH = 4;
    localparam int PRE = 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [2:0]      awprot = '0, arprot = '0;
    logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic            arvalid = 1'b0, rready = 1'b0;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [31:0]     rdata;
    logic [NCH-1:0]  led_o;

    always #5 clk = ~clk;

    axil_led_pwm_controller #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_CH             (NCH),
        .CNT_WIDTH          (16),
        .PRESCALE           (PRE)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rstn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .led_o           (led_o)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        exp_t e;
        chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic sb_drop();
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_resp,
                             input string tag);
        bit aw_ok, w_ok, ra, rw;
        int n;
        sb_push(tag, 64'(exp_resp));
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 20) begin
            ra = awready && awvalid;
            rw = wready && wvalid;
            step();
            n++;
            if (ra) begin aw_ok = 1; awvalid = 1'b0; end
            if (rw) begin w_ok = 1; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        if (bvalid) sb_check(64'(bresp));
        else sb_drop();
        step();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        int n;
        sb_push(tag, 64'({exp_data, exp_resp}));
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin step(); n++; end
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        if (rvalid) sb_check(64'({rdata, rresp}));
        else sb_drop();
        step();
        rready = 1'b0;
    endtask

    task automatic wait_level(input int b, input logic lvl, input string tag);
        int n;
        n = 0;
        while (led_o[b] !== lvl && n < 300) begin step(); n++; end
        chk({tag, "_reached"}, 64'(led_o[b]), 64'(lvl));
    endtask

    task automatic run_len(input int b, input logic lvl, output int n);
        n = 0;
        while (led_o[b] === lvl && n < 300) begin step(); n++; end
    endtask

    task automatic cycles_to_high(input int b, output int n);
        n = 0;
        while (led_o[b] !== 1'b1 && n < 300) begin step(); n++; end
    endtask

    initial begin
        int n;
        int cnt;
        int bcount;
        bit hs;

        // ---- reset state ----
        #1;
        chk("reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, led_o}), 64'd0);
        repeat (3) step();
        rstn = 1'b1;
        step();
        axi_read(6'h00, 32'h0, OKAY, "rd_ctrl_reset");
        axi_read(6'h04, 32'h0, OKAY, "rd_status_reset");

        // ---- register readback and strobes ----
        axi_write(6'h10, 32'h0001_0003, 4'hF, OKAY, "wr_ch0_cfg");
        axi_write(6'h14, 32'h0000_000A, 4'hF, OKAY, "wr_ch0_per");
        axi_read(6'h10, 32'h0001_0003, OKAY, "rd_ch0_cfg");
        axi_read(6'h14, 32'h0000_000A, OKAY, "rd_ch0_per");
        axi_write(6'h18, 32'hFFFF_FFFF, 4'h1, OKAY, "wr_ch1_cfg_b0");
        axi_read(6'h18, 32'h0000_0003, OKAY, "rd_ch1_cfg_b0");
        axi_write(6'h18, 32'h1234_5678, 4'hC, OKAY, "wr_ch1_cfg_hi");
        axi_read(6'h18, 32'h1234_0003, OKAY, "rd_ch1_cfg_hi");
        axi_read(6'h13, 32'h0001_0003, OKAY, "rd_ch0_cfg_unaligned");

        // ---- error responses ----
        axi_write(6'h08, 32'hDEAD_BEEF, 4'hF, SLVERR, "wr_id");
        axi_read(6'h08, 32'h4C45_4432, OKAY, "rd_id");
        axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, SLVERR, "wr_status");
        axi_write(6'h3C, 32'h1111_1111, 4'hF, SLVERR, "wr_unmapped");
        axi_read(6'h3C, 32'h0, SLVERR, "rd_unmapped");

        // ---- handshake ordering: W three cycles ahead, bready held off ----
        wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        chk("ho_wready_first", 64'(wready), 64'd1);
        step();
        wvalid = 1'b0;
        chk("ho_w_held", 64'({awready, wready}), 64'b10);
        step(); step();
        awaddr = 6'h2C; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        sb_push("ho_bresp", 64'(OKAY));
        bcount = 0;
        for (int k = 0; k < 10; k++) begin
            bready = (k >= 5);
            if (k < 5) chk("ho_readies_low", 64'({awready, wready}), 64'd0);
            if (k == 5) chk("ho_bvalid_waiting", 64'(bvalid), 64'd1);
            hs = bvalid && bready;
            if (hs) sb_check(64'(bresp));
            step();
            if (hs) bcount++;
        end
        bready = 1'b0;
        chk("ho_b_count", 64'(bcount), 64'd1);
        chk("ho_readies_back", 64'({awready, wready}), 64'b11);
        axi_read(6'h2C, 32'h0000_0055, OKAY, "rd_ch3_per");

        // ---- PWM on CH0: PERIOD=9, DUTY=3 ----
        axi_write(6'h00, 32'h1, 4'hF, OKAY, "wr_en");
        axi_write(6'h14, 32'd9, 4'hF, OKAY, "wr_pwm_per");
        axi_write(6'h10, 32'h0003_0003, 4'hF, OKAY, "wr_pwm_cfg");
        sb_push("pwm_high", 64'(3 * PRE));
        sb_push("pwm_low", 64'(7 * PRE));
        sb_push("pwm_high2", 64'(3 * PRE));
        wait_level(0, 1'b0, "pwm_sync_lo");
        wait_level(0, 1'b1, "pwm_sync_hi");
        run_len(0, 1'b1, n); sb_check(64'(n));
        run_len(0, 1'b0, n); sb_check(64'(n));
        run_len(0, 1'b1, n); sb_check(64'(n));

        axi_write(6'h10, 32'h0000_0003, 4'hF, OKAY, "wr_pwm_duty0");
        cnt = 0;
        for (int k = 0; k < 60; k++) begin if (led_o[0]) cnt++; step(); end
        chk("pwm_duty0_ones", 64'(cnt), 64'd0);
        axi_write(6'h10, 32'h0014_0003, 4'hF, OKAY, "wr_pwm_duty20");
        cnt = 0;
        for (int k = 0; k < 60; k++) begin if (!led_o[0]) cnt++; step(); end
        chk("pwm_duty20_zeros", 64'(cnt), 64'd0);

        // ---- blink on CH2: PERIOD=1 -> toggle every 2*PRE cycles ----
        axi_write(6'h24, 32'd1, 4'hF, OKAY, "wr_blink_per");
        axi_write(6'h20, 32'h0000_0002, 4'hF, OKAY, "wr_blink_cfg");
        sb_push("blink_high", 64'(2 * PRE));
        sb_push("blink_low", 64'(2 * PRE));
        wait_level(2, 1'b0, "blink_sync_lo");
        wait_level(2, 1'b1, "blink_sync_hi");
        run_len(2, 1'b1, n); sb_check(64'(n));
        run_len(2, 1'b0, n); sb_check(64'(n));

        // ---- CLR restarts the timebase; config retained, CLR reads 0 ----
        wait_level(2, 1'b1, "clr_sync_hi");
        wait_level(2, 1'b0, "clr_sync_lo");
        axi_write(6'h00, 32'h3, 4'hF, OKAY, "wr_clr");
        cycles_to_high(2, n);
        chk("clr_restart_delay", 64'(n), 64'(2 * PRE + 1));
        axi_read(6'h00, 32'h1, OKAY, "rd_ctrl_after_clr");
        axi_read(6'h24, 32'd1, OKAY, "rd_blink_per_kept");

        // ---- EN off forces LEDs low; EN on restarts from 0 ----
        wait_level(2, 1'b1, "en_sync_hi");
        axi_write(6'h00, 32'h0, 4'hF, OKAY, "wr_en_off");
        chk("en_off_led", 64'(led_o), 64'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin if (led_o != '0) cnt++; step(); end
        chk("en_off_hold", 64'(cnt), 64'd0);
        axi_write(6'h00, 32'h1, 4'hF, OKAY, "wr_en_on");
        cycles_to_high(2, n);
        chk("en_restart_delay", 64'(n), 64'(2 * PRE));

        // ---- reset while a read response is pending ----
        araddr = 6'h10; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        chk("mid_rvalid_pending", 64'(rvalid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, led_o}), 64'd0);
        step(); step();
        rstn = 1'b1;
        step();
        chk("mid_after_rvalid_led", 64'({rvalid, led_o}), 64'd0);
        axi_read(6'h00, 32'h0, OKAY, "rd_ctrl_post_rst");
        axi_read(6'h04, 32'h0, OKAY, "rd_status_post_rst");
        axi_read(6'h10, 32'h0, OKAY, "rd_ch0_cfg_post_rst");
        axi_read(6'h14, 32'h0, OKAY, "rd_ch0_per_post_rst");
        axi_read(6'h20, 32'h0, OKAY, "rd_ch2_cfg_post_rst");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/axil_led_pwm_controller.md
Name: axil_led_pwm_controller

Overview:
AXI4-Lite slave that drives NUM_CH LED outputs. Each channel has its own mode: off, on, blink or PWM, with a programmable period and duty.
It generalises the 4-register FMC LED controller to a parametrised channel count, byte-strobe writes, error responses, and a timebase shared by all channels.
It sits behind the block-design AXI interconnect, and the master VIP drives it in simulation.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 0x10+8*NUM_CH <= 2**C_S_AXI_ADDR_WIDTH.
NUM_CH, 4, number of LED channels, 1..6 at the default address width.
CNT_WIDTH, 16, width of the per-channel period, duty and counter fields (<=16).
PRESCALE, 100, ACLK cycles per timebase tick (>=1).

Ports:
s00_axi_aclk in 1 — the single clock.
s00_axi_aresetn in 1 — reset, asynchronous and active-low.
s00_axi_awaddr in C_S_AXI_ADDR_WIDTH; s00_axi_awprot in 3 (ignored); s00_axi_awvalid in 1; s00_axi_awready out 1
s00_axi_wdata in 32; s00_axi_wstrb in 4; s00_axi_wvalid in 1; s00_axi_wready out 1
s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1
s00_axi_araddr in C_S_AXI_ADDR_WIDTH; s00_axi_arprot in 3 (ignored); s00_axi_arvalid in 1; s00_axi_arready out 1
s00_axi_rdata out 32; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1
led_o out NUM_CH — registered LED drive.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset state: every AXI output is 0; all registers are 0; led_o is 0; prescaler and channel counters are 0.
- Register map (word aligned; addr[1:0] ignored):
  - 0x00 CTRL (RW): [0] EN global enable; [1] CLR, self-clearing, reads 0.
  - 0x04 STATUS (RO): [NUM_CH-1:0] = led_o.
  - 0x08 ID (RO): 0x4C454432.
  - 0x10+8i CHi_CFG (RW): [1:0] MODE (0 off, 1 on, 2 blink, 3 pwm); [31:16] DUTY.
  - 0x14+8i CHi_PERIOD (RW): [CNT_WIDTH-1:0] PERIOD.
  - Unused bits read 0.
- Write channel:
  - AW and W are accepted independently, each into a one-entry holding register.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - When both are held, the write is performed in the next cycle, honouring WSTRB per byte. bvalid rises in that same cycle and holds until bready.
  - BRESP: OKAY for a mapped RW address. SLVERR (2'b10) for an RO or unmapped address; such a write has no effect.
  - Only one write is outstanding at a time.
- Read channel:
  - arready = !rvalid.
  - rvalid rises 1 cycle after the AR handshake; rdata and rresp are held until rready.
  - Unmapped address: rdata = 0, RRESP = SLVERR.
- Read and write are independent. A read of a register in the same cycle it is written returns the old value.
- Timebase:
  - Prescaler counts 0..PRESCALE-1; tick pulses for one cycle on the wrap.
  - With PRESCALE=1, tick is asserted every cycle.
- Per-channel counter (on tick):
  - cnt = (cnt >= PERIOD) ? 0 : cnt+1.
  - PERIOD=0: cnt stays at 0.
- LED next-state per mode:
  - off → 0; on → 1.
  - blink → toggles on each tick where cnt wraps (cnt >= PERIOD and PERIOD != 0); holds its value when PERIOD = 0.
  - pwm → (cnt < DUTY). DUTY > PERIOD gives constant 1; DUTY = 0 gives constant 0.
- led_o is registered: it changes 1 cycle after the counter or config change that causes it.
- Writing CHi_PERIOD, or CHi_CFG with a changed MODE, clears cnt and the blink state of that channel in the write cycle.
- EN=0: prescaler, all counters and blink states are held at 0, and led_o = 0, regardless of mode.
- CLR=1 written: prescaler, all counters and blink states are cleared in the following cycle; configuration registers are retained.
- Reset mid-transaction: the pending B/R and held AW/W are dropped, and all valids are 0 while reset is asserted.

Decomposition:
- Package axil_led_pkg holds:
  - led_mode_e enum (OFF, ON, BLINK, PWM);
  - address offset constants CTRL/STATUS/ID/CH_BASE/CH_STRIDE;
  - ID constant;
  - RESP_OKAY / RESP_SLVERR.
- Sub-module led_channel: one instance per channel (generate loop). Inputs: clk, rstn, tick, en, clr, mode, period, duty, cfg_wr. Output: led. It contains the counter, blink flop and output register.
- The top level holds the AXI FSMs, the register file and the prescaler.

Test Plan:
- Register readback: write 0x00010003 to CH0_CFG and 0x000A to CH0_PERIOD with wstrb=0xF → read back 0x00010003 and 0x0000000A, RRESP=OKAY. Write 0xFFFFFFFF to CH1_CFG with wstrb=0x1 → reads 0x00000003.
- Errors: write to ID → BRESP=SLVERR and ID still reads 0x4C454432. Read 0x3C with NUM_CH=4 → rdata=0, RRESP=SLVERR.
- Handshake ordering: W presented 3 cycles before AW, with bready held low for 5 cycles → exactly one B; awready and wready stay 0 until the B handshake.
- PWM: PRESCALE=1, EN=1, CH0 mode=pwm, PERIOD=9, DUTY=3 → led_o[0] shows a repeating pattern of 3 cycles high, 7 cycles low. DUTY=0 → constant 0; DUTY=20 → constant 1.
- Blink: PRESCALE=4, CH2 mode=blink, PERIOD=1 → led_o[2] toggles every 8 cycles. Clearing EN → led_o=0 within 1 cycle. Setting EN=1 again restarts the pattern from 0.
- Reset mid-read: assert s00_axi_aresetn=0 while rvalid=1 → rvalid, led_o and all registers read 0 after release; STATUS reads 0.
